axi_sram_slave: RTL
===================

# axi_sram_slave

AXI3 slave responder that serves the burst traffic issued by the CPU's AXI master bridge (icache line/word reads, dcache line/word reads and writes) from an on-chip word-addressed memory array. It sits on the far side of the CPU's AXI port in the simulation/FPGA SoC, in place of the external memory controller. It handles one transaction at a time: INCR bursts with a configurable length and byte-strobed writes. Write requests have priority over reads so that a read issued after a write observes the written data.

## Interface
- `ADDR_W`, default 14: word-index width; the array holds 2^ADDR_W 32-bit words.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst` in 4/32/8/3/2: read address channel. `arsize` and `arburst` are ignored; beats are always 4 bytes, INCR.
- `arlock`/`arcache`/`arprot` in 2/4/3: ignored.
- `arvalid` in 1, `arready` out 1: AR handshake.
- `rid` out 4, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1: read data channel.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst` in 4/32/8/3/2: write address channel. `awsize` and `awburst` are ignored.
- `awlock`/`awcache`/`awprot` in 2/4/3: ignored.
- `awvalid` in 1, `awready` out 1: AW handshake.
- `wid` in 4 (ignored), `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1, `wready` out 1: write data channel.
- `bid` out 4, `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.

## Operation
- FSM states: IDLE, RD, WR, WRESP. The reset state is IDLE.
- `awready` = IDLE && resetn. `arready` = IDLE && resetn && !awvalid, so a write wins a same-cycle AR/AW contest.
- AW handshake:
  - Latches `awid`, the word index `awaddr[ADDR_W+1:2]`, and an 8-bit beat counter = `awlen`.
  - Next state is WR.
- WR state:
  - `wready`=1.
  - On each W handshake, write `mem[idx]` byte-lane-wise: lane k is written only if `wstrb[k]`=1.
  - After each beat, idx increments by 1 modulo 2^ADDR_W and the counter decrements by 1.
  - The burst ends on the beat where counter==0, regardless of `wlast`. That beat's `wlast` is compared: if `wlast` is 0 on the final beat, or 1 on any earlier beat, a sticky error flag is set.
  - After the final beat, go to WRESP.
- WRESP state:
  - `bvalid`=1, `bid`=latched awid, `bresp`=2'b10 if the error flag is set, else 2'b00.
  - On `bready`, clear the flag and go to IDLE.
- AR handshake:
  - Latches `arid`, the word index, and counter = `arlen`.
  - Next state is RD.
- RD state:
  - `rvalid`=1, `rdata`=mem[idx] (asynchronous array read), `rid`=latched arid, `rresp`=2'b00, `rlast`=(counter==0).
  - On `rready`, idx increments modulo 2^ADDR_W and the counter decrements. The beat with `rlast` returns to IDLE.
- Address bits above ADDR_W+1 and `araddr[1:0]`/`awaddr[1:0]` are ignored (aliasing).
- Memory contents are not reset.

## Timing
- Values while `resetn`=0 and on the first cycle after release: `arready`=`awready`=0 while `resetn`=0, then 1 from the first cycle after release. `rvalid`=`wready`=`bvalid`=`rlast`=0. `rid`=`bid`=0, `rresp`=`bresp`=0, `rdata`=0 outside RD.
- Read latency: AR handshake in cycle T gives first `rvalid` in T+1. Each subsequent beat follows one cycle after the previous R handshake. A burst of N beats with `rready` held high occupies T+1..T+N.
- Write: AW handshake in T gives `wready` from T+1. The final W beat in cycle U gives `bvalid` at U+1. The B handshake returns the FSM to IDLE, with `awready`/`arready` high one cycle later.
- Stall, reads: `rready`=0 holds `rvalid`, `rdata`, `rid` and `rlast` stable.
- Stall, writes: `wvalid`=0 in WR inserts idle cycles and writes nothing. `bready`=0 holds `bvalid`/`bid`/`bresp`.
- No handshake is accepted on AR/AW outside IDLE. `arlen`=0/`awlen`=0 is a single-beat transfer (the uncached case).
- `resetn` low mid-burst: the next edge forces IDLE and drops all valid/ready outputs. Beats already written stay in memory. Remaining beats and responses are abandoned.
- Wrap-around: a burst starting at word 2^ADDR_W-2 with len 3 accesses words 2^ADDR_W-2, 2^ADDR_W-1, 0, 1.

## Test plan
- Reset, then write line: AW(id=1, addr=0x1C000010, len=3) then W beats 0x11111111..0x44444444 with strb=0xF, `wlast` on beat 4 -> `bvalid` one cycle after beat 4 with bid=1, bresp=00. Words 4..7 hold the data.
- Read line back: AR(id=0, addr=0x1C000010, len=3), `rready`=1 -> rvalid at T+1..T+4, rdata 0x11111111..0x44444444, rlast only on beat 4, rid=0.
- Uncached strobed write: AW len=0, addr=0x1C000014, wdata=0xAABBCCDD, wstrb=0x3 -> word 5 becomes 0x2222CCDD. A subsequent single-beat read returns 0x2222CCDD with rlast=1.
- Same-cycle AR(id=1) and AW(id=1): `awready`=1 and `arready`=0 in that cycle. The write completes first. The read is accepted in the cycle after the B handshake and returns the new data.
- Backpressure: `rready` low for 3 cycles mid-burst -> rdata/rlast held constant, no beat skipped. `bready` low for 2 cycles -> bvalid held.
- Protocol error and reset: W burst with `wlast` asserted on beat 2 of len=3 -> all 4 beats written, bresp=2'b10. Then `resetn` dropped during RD beat 2 -> next cycle rvalid=0. After release, IDLE with arready=1.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the CPU's AXI master bridge and the SRAM responder.
// Carries the five channels AR, R, AW, W and B.
//   master modport : drives the AR/AW/W channels and rready/bready.
//   slave modport  : drives arready/awready/wready and the R/B channels.
// The clock and reset are not part of this bundle. They stay plain ports on
// each module.
interface axi_sram_slave_if;
    // read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    // read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    // write data channel
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave that serves INCR bursts from an on-chip array of 2^ADDR_W 32-bit
// words. It handles one transaction at a time. When AR and AW arrive in the
// same cycle, the write is accepted first, so a later read sees the new data.
// Ports:
//   clk    : sole clock, rising edge
//   resetn : synchronous active-low reset
//   axi    : AXI3 slave modport (AR, R, AW, W, B channels)
// Every beat is 4 bytes. The size, burst type, lock, cache, prot and wid
// fields are ignored. Address bits outside [ADDR_W+1:2] alias.
module axi_sram_slave #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              resetn,
    axi_sram_slave_if.slave   axi
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_cnt;
    logic [3:0]        r_id;
    logic              r_err;

    logic [31:0]       w_mem_rdata;
    logic              w_last_beat;
    logic              w_ar_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_r_hs;
    logic              w_b_hs;
    logic              w_unused;

    assign w_last_beat = (r_cnt == 8'd0);
    assign w_ar_hs     = axi.arvalid && axi.arready;
    assign w_aw_hs     = axi.awvalid && axi.awready;
    assign w_w_hs      = axi.wvalid  && axi.wready;
    assign w_r_hs      = axi.rvalid  && axi.rready;
    assign w_b_hs      = axi.bvalid  && axi.bready;

    // Fields accepted on the bus but not used by the design.
    assign w_unused = ^{axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot,
                        axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot,
                        axi.wid, axi.araddr[31:ADDR_W+2], axi.araddr[1:0],
                        axi.awaddr[31:ADDR_W+2], axi.awaddr[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every output is forced low while resetn is low. This covers the time
    // before the first reset edge, and a reset asserted in the middle of a
    // burst.
    always_comb begin
        w_state_next = r_state;
        axi.arready  = 1'b0;
        axi.awready  = 1'b0;
        axi.rvalid   = 1'b0;
        axi.rdata    = 32'd0;
        axi.rid      = 4'd0;
        axi.rresp    = 2'b00;
        axi.rlast    = 1'b0;
        axi.wready   = 1'b0;
        axi.bvalid   = 1'b0;
        axi.bid      = 4'd0;
        axi.bresp    = 2'b00;
        if (resetn) begin
            unique case (r_state)
                IDLE: begin
                    axi.awready = 1'b1;
                    axi.arready = !axi.awvalid;   // a pending write takes priority
                    if (axi.awvalid) begin
                        w_state_next = WR;
                    end else if (axi.arvalid) begin
                        w_state_next = RD;
                    end
                end
                RD: begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = w_mem_rdata;
                    axi.rid    = r_id;
                    axi.rlast  = w_last_beat;
                    if (axi.rready && w_last_beat) begin
                        w_state_next = IDLE;
                    end
                end
                WR: begin
                    axi.wready = 1'b1;
                    if (axi.wvalid && w_last_beat) begin
                        w_state_next = WRESP;
                    end
                end
                WRESP: begin
                    axi.bvalid = 1'b1;
                    axi.bid    = r_id;
                    axi.bresp  = r_err ? 2'b10 : 2'b00;
                    if (axi.bready) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Burst bookkeeping. The beat counter, not wlast, decides where a write
    // burst ends. A wlast that disagrees with the counter sets the sticky
    // error flag, which is reported in bresp.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idx <= '0;
            r_cnt <= 8'd0;
            r_id  <= 4'd0;
            r_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_id  <= axi.awid;
            r_idx <= axi.awaddr[ADDR_W+1:2];
            r_cnt <= axi.awlen;
            r_err <= 1'b0;
        end else if (w_ar_hs) begin
            r_id  <= axi.arid;
            r_idx <= axi.araddr[ADDR_W+1:2];
            r_cnt <= axi.arlen;
        end else if (w_w_hs || w_r_hs) begin
            r_idx <= r_idx + IDX_ONE;         // wraps modulo the array size
            r_cnt <= r_cnt - 8'd1;
            if (w_w_hs && (axi.wlast != w_last_beat)) begin
                r_err <= 1'b1;
            end
        end else if (w_b_hs) begin
            r_err <= 1'b0;
        end
    end

    // One byte-wide array per lane, so that each strobe bit controls its own
    // write enable. Reads are asynchronous, so rdata follows r_idx in the same
    // cycle. Memory contents are not reset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [0:DEPTH-1];
            always_ff @(posedge clk) begin
                if (w_w_hs && axi.wstrb[gi]) begin
                    r_lane[r_idx] <= axi.wdata[gi*8 +: 8];
                end
            end
            assign w_mem_rdata[gi*8 +: 8] = r_lane[r_idx];
        end
    endgenerate
endmodule
